// File: rtl/jk_pkg.sv
// jk_pkg: shared op codes, FSM states and limits
// for the JK bank stimulus driver.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_HOLD   = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_CLEAR  = 2'b11
  } jk_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_POST,
    ST_CHECK
  } jk_state_t;

  localparam logic [7:0] PASS_MAX = 8'd255;

endpackage

// File: rtl/jk_excite.sv
// jk_excite: per-bit J/K excitation; TOGGLE drives
// J=K=mask, otherwise the inverse JK table on (q, e).
module jk_excite (
  input  logic q,
  input  logic e,
  input  logic tog,
  input  logic m,
  output logic j,
  output logic k
);

  assign j = tog ? m : (~q & e);
  assign k = tog ? m : (q & ~e);

endmodule

// File: rtl/jk_seq_driver.sv
// jk_seq_driver: command-driven J/K stimulus and Q checker.
// Define JK_VERIFY_EN to compare Q against the expected value.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             jk_clk_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err,
  output logic [7:0]       pass_cnt
);

  localparam logic [3:0] SET_M1 = 4'(SETTLE - 1);

  jk_state_t        state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] jn;
  logic [WIDTH-1:0] kn;
  logic             tog;
  logic             ok;

  assign cmd_ready = (state == ST_IDLE);
  assign tog       = (cmd_op == OP_TOGGLE);

  always_comb begin
    e = '0;
    unique case (cmd_op)
      OP_LOAD:   e = cmd_data;
      OP_HOLD:   e = q_in;
      OP_TOGGLE: e = q_in ^ cmd_data;
      OP_CLEAR:  e = '0;
      default:   e = '0;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_excite u_ex (
      .q   (q_in[i]),
      .e   (e[i]),
      .tog (tog),
      .m   (cmd_data[i]),
      .j   (jn[i]),
      .k   (kn[i])
    );
  end

`ifdef JK_VERIFY_EN
  logic [WIDTH-1:0] exp_q;
  logic             err_q;
  assign ok  = (q_in == exp_q);
  assign err = err_q;
`else
  assign ok  = 1'b1;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      j_out      <= '0;
      k_out      <= '0;
      jk_clk_out <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
`ifdef JK_VERIFY_EN
      exp_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state <= ST_SETUP;
            cnt   <= SET_M1;
            j_out <= jn;
            k_out <= kn;
`ifdef JK_VERIFY_EN
            exp_q <= e;
`endif
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            state      <= ST_STROBE;
            cnt        <= SET_M1;
            jk_clk_out <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          state      <= ST_POST;
          cnt        <= SET_M1;
          jk_clk_out <= 1'b0;
        end
        ST_POST: begin
          if (cnt == 4'd0) begin
            state <= ST_CHECK;
            cnt   <= SET_M1;
            done  <= 1'b1;
            j_out <= '0;
            k_out <= '0;
`ifdef JK_VERIFY_EN
            err_q <= ~ok;
`endif
            // saturate rather than wrap
            if (ok && pass_cnt != PASS_MAX)
              pass_cnt <= pass_cnt + 8'd1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          cnt   <= SET_M1;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: drives commands into the driver with a
// behavioural JK bank and checks against a command-level model.
module tb_jk_seq_driver;

  localparam int W = 8;
  localparam int S = 3;

`ifdef JK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] j_out;
  logic [W-1:0] k_out;
  logic         jk_clk_out;
  logic [W-1:0] q_in;
  logic         done;
  logic         err;
  logic [7:0]   pass_cnt;

  logic [W-1:0] bank_q = '0;
  logic         stuck = 1'b0;

  int checks = 0;
  int passed = 0;
  int exp_pass = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  jk_seq_driver #(.WIDTH(W), .SETTLE(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .j_out      (j_out),
    .k_out      (k_out),
    .jk_clk_out (jk_clk_out),
    .q_in       (q_in),
    .done       (done),
    .err        (err),
    .pass_cnt   (pass_cnt)
  );

  // behavioural JK bank, bit 0 optionally stuck at 1
  assign q_in = bank_q | {{(W-1){1'b0}}, stuck};

  always @(posedge jk_clk_out) begin
    for (int i = 0; i < W; i++) begin
      case ({j_out[i], k_out[i]})
        2'b01:   bank_q[i] <= 1'b0;
        2'b10:   bank_q[i] <= 1'b1;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  task automatic run_cmd(input logic [1:0] op,
                         input logic [W-1:0] data,
                         input bit hold);
    logic [W-1:0] qs, expq, ej, ek, qf;
    bit ok;
    int n;
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1)
      $display("FAIL ready_wait got=%b want=1", cmd_ready);
    else passed++;
    qs = q_in;
    case (op)
      2'd0:    expq = data;
      2'd1:    expq = qs;
      2'd2:    expq = qs ^ data;
      default: expq = '0;
    endcase
    if (op == 2'd2) begin
      ej = data;
      ek = data;
    end else begin
      ej = expq & ~qs;
      ek = qs & ~expq;
    end
    qf = expq | {{(W-1){1'b0}}, stuck};
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2*S+3; c++) begin
      @(negedge clk);
      if (!hold || c == 2*S+3) cmd_valid = 1'b0;
      cmd_data = W'($urandom);
      cmd_op = 2'($urandom);
      if (c <= 2*S+1) begin
        checks++;
        if (j_out !== ej)
          $display("FAIL j c=%0d got=%h want=%h", c, j_out, ej);
        else passed++;
        checks++;
        if (k_out !== ek)
          $display("FAIL k c=%0d got=%h want=%h", c, k_out, ek);
        else passed++;
      end
      checks++;
      if (jk_clk_out !== (c == S+1))
        $display("FAIL strobe c=%0d got=%b", c, jk_clk_out);
      else passed++;
      checks++;
      if (done !== (c == 2*S+2))
        $display("FAIL done c=%0d got=%b", c, done);
      else passed++;
      checks++;
      if (cmd_ready !== (c == 2*S+3))
        $display("FAIL ready c=%0d got=%b", c, cmd_ready);
      else passed++;
      if (c == 2*S+2) begin
        ok = VERIFY ? (qf == expq) : 1'b1;
        exp_err = VERIFY && (qf != expq);
        if (ok && exp_pass < 255) exp_pass++;
        checks++;
        if (q_in !== qf)
          $display("FAIL bank_q got=%h want=%h", q_in, qf);
        else passed++;
        checks++;
        if (j_out !== '0 || k_out !== '0)
          $display("FAIL jk_clear got=%h/%h want=0", j_out, k_out);
        else passed++;
      end
      if (c >= 2*S+2) begin
        checks++;
        if (err !== exp_err)
          $display("FAIL err c=%0d got=%b want=%b", c, err, exp_err);
        else passed++;
        checks++;
        if (pass_cnt !== 8'(exp_pass))
          $display("FAIL pass_cnt c=%0d got=%0d want=%0d",
                   c, pass_cnt, exp_pass);
        else passed++;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || jk_clk_out !== 1'b0 || done !== 1'b0)
      $display("FAIL rst_ctl got=%b%b%b want=100",
               cmd_ready, jk_clk_out, done);
    else passed++;
    checks++;
    if (j_out !== '0 || k_out !== '0 || err !== 1'b0 || pass_cnt !== 8'd0)
      $display("FAIL rst_data got=%h %h %b %0d want=0",
               j_out, k_out, err, pass_cnt);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_load();
    run_cmd(2'd0, 8'hA5, 1'b0);
    checks++;
    if (q_in !== 8'hA5 || pass_cnt !== 8'd1)
      $display("FAIL load_a5 got=%h/%0d want=a5/1", q_in, pass_cnt);
    else passed++;
  endtask

  task automatic test_toggle();
    run_cmd(2'd2, 8'hFF, 1'b0);
    checks++;
    if (q_in !== 8'h5A)
      $display("FAIL toggle1 got=%h want=5a", q_in);
    else passed++;
    run_cmd(2'd2, 8'hFF, 1'b0);
    checks++;
    if (q_in !== 8'hA5 || pass_cnt !== 8'd3)
      $display("FAIL toggle2 got=%h/%0d want=a5/3", q_in, pass_cnt);
    else passed++;
  endtask

  task automatic test_hold_clear();
    run_cmd(2'd1, 8'h3C, 1'b0);
    run_cmd(2'd3, 8'h77, 1'b0);
    checks++;
    if (q_in !== 8'h00 || pass_cnt !== 8'd5)
      $display("FAIL clear got=%h/%0d want=00/5", q_in, pass_cnt);
    else passed++;
  endtask

  task automatic test_stuck_busy();
    stuck = 1'b1;
    run_cmd(2'd0, 8'h00, 1'b1);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== exp_err)
      $display("FAIL stuck_after got=%b%b%b", cmd_ready, done, err);
    else passed++;
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q0;
    bit bad;
    @(negedge clk);
    q0 = q_in;
    cmd_op = 2'd0;
    cmd_data = ~q0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || jk_clk_out !== 1'b0 || done !== 1'b0)
      $display("FAIL mid_ctl got=%b%b%b want=100",
               cmd_ready, jk_clk_out, done);
    else passed++;
    checks++;
    if (j_out !== '0 || k_out !== '0 || pass_cnt !== 8'd0 || err !== 1'b0)
      $display("FAIL mid_data got=%h %h %0d %b",
               j_out, k_out, pass_cnt, err);
    else passed++;
    exp_pass = 0;
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (jk_clk_out !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
        bad = 1'b1;
    end
    checks++;
    if (bad)
      $display("FAIL mid_quiet got=activity want=idle");
    else passed++;
    checks++;
    if (q_in !== q0)
      $display("FAIL mid_bank got=%h want=%h", q_in, q0);
    else passed++;
  endtask

  task automatic test_random_saturate();
    for (int i = 0; i < 260; i++)
      run_cmd(2'($urandom_range(3)), W'($urandom), 1'b0);
    checks++;
    if (pass_cnt !== 8'd255)
      $display("FAIL saturate got=%0d want=255", pass_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_toggle();
    test_hold_clear();
    test_stuck_busy();
    test_reset_mid();
    test_random_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jk_seq_driver.md
# jk_seq_driver

Command-driven stimulus generator and self-checker for an external bank of JK flip-flops. It accepts high-level register operations over a valid/ready handshake and converts each one into per-bit J/K excitation values. It then issues a single clock strobe to the bank, samples the returned Q, and reports pass or fail. It sits on the driving side of the JK bank interface and replaces hand-timed J/K/clock stimulus in the lab2 flow.

## Interface
- `WIDTH`, default 8: number of JK flip-flops driven (1–32).
- `SETTLE`, default 3: idle cycles before the strobe and again after it (1–15).
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: operation code.
  - 00 LOAD
  - 01 HOLD
  - 10 TOGGLE
  - 11 CLEAR
- `cmd_data` in WIDTH: LOAD target value, or TOGGLE bit mask.
- `j_out` out WIDTH: J inputs to the bank.
- `k_out` out WIDTH: K inputs to the bank.
- `jk_clk_out` out 1: one-cycle strobe used as the bank clock.
- `q_in` in WIDTH: Q outputs of the bank.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: mismatch flag, valid while `done` is high.
- `pass_cnt` out 8: count of passing commands, saturates at 255.

## Operation
- FSM states: IDLE, SETUP, STROBE, POST, CHECK.
- IDLE:
  - `cmd_ready` = 1.
  - When `cmd_valid` is 1, the command is accepted and the FSM goes to SETUP.
  - At acceptance the block captures `q_snap` = `q_in` and computes `exp`.
- Expected value `exp` per operation:
  - LOAD: `exp` = `cmd_data`.
  - HOLD: `exp` = `q_snap`.
  - TOGGLE: `exp` = `q_snap ^ cmd_data`.
  - CLEAR: `exp` = 0.
- J/K excitation per bit, registered at acceptance:
  - TOGGLE: J = K = `cmd_data[i]`.
  - All other operations use the inverse JK table on (`q_snap[i]`, `exp[i]`):
    - 0→0: J=0, K=0.
    - 0→1: J=1, K=0.
    - 1→0: J=0, K=1.
    - 1→1: J=0, K=0.
  - J=K=1 is therefore only ever driven by TOGGLE.
- SETUP: J/K are held stable for `SETTLE` cycles, then the FSM goes to STROBE.
- STROBE: `jk_clk_out` = 1 for exactly one cycle, then the FSM goes to POST.
- POST: `SETTLE` cycles with J/K still held, then the FSM goes to CHECK.
- CHECK: lasts one cycle.
  - `err` = (`q_in` != `exp`), `done` = 1.
  - If `err` = 0, `pass_cnt` increments, saturating at 255.
  - `j_out`/`k_out` return to 0 and the FSM goes to IDLE.
- `cmd_valid` while the FSM is not in IDLE is ignored; no queueing.

## Timing
- Reset values:
  - State = IDLE.
  - `cmd_ready` = 1; `cmd_ready` is decoded from state.
  - `j_out` = `k_out` = 0, `jk_clk_out` = 0.
  - `done` = 0, `err` = 0, `pass_cnt` = 0.
- Latency: command accepted on edge 0.
  - `jk_clk_out` is high in cycle `SETTLE`+1.
  - `done` is high in cycle 2·`SETTLE`+2.
  - `cmd_ready` returns to 1 in the cycle after `done`.
- Back-to-back throughput is one command per 2·`SETTLE`+3 cycles.
- `err` holds its value until the next CHECK.
- `done` is a one-cycle pulse.
- Reset asserted mid-command: the FSM returns to IDLE at once and all outputs take their reset values. `jk_clk_out` drops without completing a strobe. `pass_cnt` clears.
- The SETTLE counter is 4 bits and reloads on every state entry.

## Configuration
- `JK_VERIFY_EN` defined:
  - CHECK compares `q_in` against `exp`.
  - `err` and `pass_cnt` behave as described above.
- `JK_VERIFY_EN` undefined:
  - No comparison logic; `exp` and `q_in` sampling in CHECK are removed.
  - `err` is tied to 0.
  - `pass_cnt` counts every completed command.
  - FSM states and latency are identical.

## Structure
- Shared package `jk_pkg` holds:
  - `cmd_op` encodings: OP_LOAD, OP_HOLD, OP_TOGGLE, OP_CLEAR.
  - FSM state encodings.
  - `PASS_MAX` = 255.
- Sub-module `jk_excite`: combinational, one instance per bit via generate.
  - Inputs: `q`, `e`, `tog`, `m`.
  - Outputs: `j`, `k`.
- `jk_seq_driver` contains the FSM, counters and registers.

## Test plan
The bench uses `WIDTH`=8 and `SETTLE`=3, and models the bank with 8 behavioral JK flip-flops clocked by `jk_clk_out`.
- Reset, then LOAD 0xA5 from Q=0x00 → J=0xA5, K=0x00 during SETUP; strobe in cycle 4; `done` in cycle 8; Q=0xA5; `err`=0; `pass_cnt`=1.
- TOGGLE 0xFF from Q=0xA5 → J=K=0xFF; Q=0x5A; `err`=0. Repeat: Q=0xA5; `pass_cnt`=3.
- HOLD from Q=0xA5 → J=K=0x00; Q stays 0xA5. Then CLEAR → K=0xA5; Q=0x00; `pass_cnt`=5.
- Stuck bank model (bit 0 forced 1), LOAD 0x00 → `err`=1 with `done`; `pass_cnt` unchanged. `cmd_valid` held during the busy period → no extra accept.
- Reset pulsed in cycle 2 of a LOAD → no strobe, `done` stays 0, `pass_cnt`=0, `cmd_ready`=1 once reset is released.
- 260 passing commands → `pass_cnt`=255 (saturates). Rebuild without `JK_VERIFY_EN`, repeat the stuck-bit case → `err`=0, `pass_cnt` increments.
